// File: rtl/mem_pkg.sv
// Shared definitions for the memory access unit: access sizes, FSM states and RAM depth.
package mem_pkg;

   localparam int RAM_DEPTH = 256;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } size_t;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ACCESS = 2'b01,
      FINISH = 2'b10
   } state_t;

   // Index of the last byte of an access (N-1); the reserved size never reaches ACCESS.
   function automatic logic [1:0] last_index(input logic [1:0] size);
      case (size)
         SZ_HALF: last_index = 2'd1;
         SZ_WORD: last_index = 2'd3;
         default: last_index = 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/data_ram256x8.sv
// Byte-wide data RAM: combinational read, write on the rising edge while enabled.
module data_ram256x8 (
   input  logic       clk,
   input  logic       enable,
   input  logic       read_write,
   input  logic [7:0] address,
   input  logic [7:0] data_in,
   output logic [7:0] data_out
);

   logic [7:0] mem [256];

   // Store the presented byte when a write transfer is enabled.
   always_ff @(posedge clk) begin
      if (enable && read_write) begin
         mem[address] <= data_in;
      end
   end

   assign data_out = mem[address];

endmodule

// File: rtl/mem_extend.sv
// Turns the assembled load bytes into the final 32-bit result (zero or sign extension).
module mem_extend
   import mem_pkg::*;
(
   input  logic [31:0] assembled,
   input  logic [1:0]  size,
   input  logic        sign_ext,
   output logic [31:0] value
);

   // Widen byte and halfword loads; word loads pass through regardless of sign_ext.
   always_comb begin
      value = assembled;
      case (size)
         SZ_BYTE: value = {{24{sign_ext & assembled[7]}}, assembled[7:0]};
         SZ_HALF: value = {{16{sign_ext & assembled[15]}}, assembled[15:0]};
         default: value = assembled;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Splits byte/halfword/word loads and stores into big-endian single-byte RAM transfers.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int RAM_DEPTH = mem_pkg::RAM_DEPTH
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        rw,
   input  logic [1:0]  size,
   input  logic        sign_ext,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        busy,
   output logic        done,
   output logic        fault,
   output logic        mem_enable,
   output logic        mem_read_write,
   output logic [31:0] mem_address,
   output logic [7:0]  mem_data_out,
   input  logic [7:0]  mem_data_in
);

   state_t      state;
   state_t      next_state;
   logic        req_rw;
   logic        req_sign_ext;
   logic        req_fault;
   logic [1:0]  req_size;
   logic [1:0]  count;
   logic [1:0]  last;
   logic [1:0]  byte_sel;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [31:0] shift;
   logic [31:0] addr_hold;
   logic [31:0] access_addr;
   logic [31:0] assembled_next;
   logic [31:0] extended;
   logic        accept;
   logic        is_fault;
   logic        last_byte;

   assign accept         = (state == IDLE) && start;
   assign last_byte      = (count == last);
   assign byte_sel       = last - count;
   assign access_addr    = req_addr + {30'b0, count};
   assign assembled_next = {shift[23:0], mem_data_in};
   assign busy           = (state != IDLE);
   assign done           = (state == FINISH);
   assign fault          = done & req_fault;

   // Reject reserved sizes, misaligned halfwords/words and addresses beyond the RAM.
   always_comb begin
      is_fault = 1'b0;
      case (size)
         SZ_BYTE: is_fault = 1'b0;
         SZ_HALF: is_fault = addr[0];
         SZ_WORD: is_fault = |addr[1:0];
         default: is_fault = 1'b1;
      endcase
      if (addr >= 32'(RAM_DEPTH)) begin
         is_fault = 1'b1;
      end
   end

   // State register; reset drops straight back to IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next state: faults skip ACCESS, legal requests leave ACCESS after their last byte.
   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:    if (start) next_state = is_fault ? FINISH : ACCESS;
         ACCESS:  if (last_byte) next_state = FINISH;
         FINISH:  next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Request latch, byte counter, load shift register and result register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_rw       <= 1'b0;
         req_sign_ext <= 1'b0;
         req_fault    <= 1'b0;
         req_size     <= 2'b00;
         req_addr     <= 32'b0;
         req_wdata    <= 32'b0;
         count        <= 2'b00;
         last         <= 2'b00;
         shift        <= 32'b0;
         addr_hold    <= 32'b0;
         rdata        <= 32'b0;
      end else if (accept) begin
         req_rw       <= rw;
         req_sign_ext <= sign_ext;
         req_fault    <= is_fault;
         req_size     <= size;
         req_addr     <= addr;
         req_wdata    <= wdata;
         count        <= 2'b00;
         last         <= last_index(size);
         shift        <= 32'b0;
      end else if (state == ACCESS) begin
         count     <= count + 2'd1;
         addr_hold <= access_addr;
         if (!req_rw) begin
            shift <= assembled_next;
            if (last_byte) begin
               rdata <= extended;
            end
         end
      end
   end

   // RAM-side outputs: one enabled transfer per ACCESS cycle, quiet bus otherwise.
   always_comb begin
      mem_enable     = 1'b0;
      mem_read_write = 1'b0;
      mem_address    = addr_hold;
      mem_data_out   = 8'b0;
      if (state == ACCESS) begin
         mem_enable     = 1'b1;
         mem_read_write = req_rw;
         mem_address    = access_addr;
         if (req_rw) begin
            mem_data_out = req_wdata[{byte_sel, 3'b000} +: 8];
         end
      end
   end

   mem_extend u_extend (
      .assembled (assembled_next),
      .size      (req_size),
      .sign_ext  (req_sign_ext),
      .value     (extended)
   );

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit with a byte-array reference model of the RAM.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        rw;
   logic [1:0]  size;
   logic        sign_ext;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        busy;
   logic        done;
   logic        fault;
   logic        mem_enable;
   logic        mem_read_write;
   logic [31:0] mem_address;
   logic [7:0]  mem_data_out;
   logic [7:0]  mem_data_in;

   logic        bd_active;
   logic        bd_en;
   logic        bd_rw;
   logic [7:0]  bd_addr;
   logic [7:0]  bd_data;
   logic        ram_en;
   logic        ram_rw;
   logic [7:0]  ram_addr;
   logic [7:0]  ram_din;

   logic [7:0]  ref_mem [256];
   logic [31:0] exp_rdata;
   logic [31:0] exp_held_addr;
   int          checks;
   int          failures;
   int          xfer_count = 0;

   mem_access_unit #(.RAM_DEPTH(256)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .rw             (rw),
      .size           (size),
      .sign_ext       (sign_ext),
      .addr           (addr),
      .wdata          (wdata),
      .rdata          (rdata),
      .busy           (busy),
      .done           (done),
      .fault          (fault),
      .mem_enable     (mem_enable),
      .mem_read_write (mem_read_write),
      .mem_address    (mem_address),
      .mem_data_out   (mem_data_out),
      .mem_data_in    (mem_data_in)
   );

   assign ram_en   = bd_active ? bd_en   : mem_enable;
   assign ram_rw   = bd_active ? bd_rw   : mem_read_write;
   assign ram_addr = bd_active ? bd_addr : mem_address[7:0];
   assign ram_din  = bd_active ? bd_data : mem_data_out;

   data_ram256x8 ram (
      .clk        (clk),
      .enable     (ram_en),
      .read_write (ram_rw),
      .address    (ram_addr),
      .data_in    (ram_din),
      .data_out   (mem_data_in)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Count RAM transfers issued by the DUT.
   always @(posedge clk) begin
      if (mem_enable && !bd_active) begin
         xfer_count <= xfer_count + 1;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   function automatic bit model_fault(input logic [1:0] s, input logic [31:0] a);
      return (s == 2'd3) || (s == 2'd1 && a % 2 != 0) || (s == 2'd2 && a % 4 != 0) || (a >= 256);
   endfunction

   task automatic checkResetOutputs();
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_fault", 32'(fault), 32'd0);
      checkOutput("rst_enable", 32'(mem_enable), 32'd0);
      checkOutput("rst_rw", 32'(mem_read_write), 32'd0);
      checkOutput("rst_addr", mem_address, 32'd0);
      checkOutput("rst_dout", 32'(mem_data_out), 32'd0);
      checkOutput("rst_rdata", rdata, 32'd0);
   endtask

   task automatic backdoorWrite(input logic [7:0] a, input logic [7:0] d);
      bd_active = 1'b1;
      bd_en     = 1'b1;
      bd_rw     = 1'b1;
      bd_addr   = a;
      bd_data   = d;
      @(posedge clk);
      #1;
      bd_en     = 1'b0;
      bd_rw     = 1'b0;
      bd_active = 1'b0;
   endtask

   task automatic backdoorRead(input logic [7:0] a, output logic [7:0] d);
      bd_active = 1'b1;
      bd_en     = 1'b0;
      bd_addr   = a;
      #1;
      d         = mem_data_in;
      bd_active = 1'b0;
   endtask

   // Issue one request at a negedge and follow it cycle by cycle until the next IDLE cycle.
   task automatic applyStimulus(input logic t_rw, input logic [1:0] t_size, input logic t_se,
                                input logic [31:0] t_addr, input logic [31:0] t_wdata);
      int          n;
      int          exp_done;
      int          base;
      bit          flt;
      bit          seen;
      logic [31:0] val;
      logic [31:0] new_hold;
      logic [7:0]  exp_byte;
      n        = (t_size == 2'd0) ? 1 : (t_size == 2'd1) ? 2 : 4;
      flt      = model_fault(t_size, t_addr);
      exp_done = flt ? 1 : n + 1;
      new_hold = flt ? exp_held_addr : t_addr + 32'(n - 1);
      if (!flt && !t_rw) begin
         val = 32'd0;
         for (int k = 0; k < n; k++) begin
            val = (val << 8) | 32'(ref_mem[8'(t_addr + 32'(k))]);
         end
         if (t_se && n < 4 && val[8 * n - 1]) begin
            val = val - (32'd1 << (8 * n));
         end
         exp_rdata = val;
      end
      base     = xfer_count;
      start    = 1'b1;
      rw       = t_rw;
      size     = t_size;
      sign_ext = t_se;
      addr     = t_addr;
      wdata    = t_wdata;
      @(posedge clk);
      seen = 1'b0;
      for (int c = 1; c <= 8 && !seen; c++) begin
         @(negedge clk);
         checkOutput("busy_active", 32'(busy), 32'd1);
         if (!flt && c <= n) begin
            checkOutput("access_enable", 32'(mem_enable), 32'd1);
            checkOutput("access_addr", mem_address, t_addr + 32'(c - 1));
            checkOutput("access_rw", 32'(mem_read_write), 32'(t_rw));
            if (t_rw) begin
               exp_byte = 8'(t_wdata >> (8 * (n - c)));
               checkOutput("write_byte", 32'(mem_data_out), 32'(exp_byte));
               ref_mem[8'(t_addr + 32'(c - 1))] = exp_byte;
            end
         end else begin
            checkOutput("quiet_enable", 32'(mem_enable), 32'd0);
         end
         if (done) begin
            seen = 1'b1;
            checkOutput("done_cycle", c, exp_done);
            checkOutput("fault_flag", 32'(fault), 32'(flt));
            checkOutput("rdata", rdata, exp_rdata);
            checkOutput("finish_addr", mem_address, new_hold);
            checkOutput("finish_bus", 32'({mem_read_write, mem_data_out}), 32'd0);
         end
         start    = 1'($urandom);
         rw       = 1'($urandom);
         size     = 2'($urandom);
         sign_ext = 1'($urandom);
         addr     = $urandom;
         wdata    = $urandom;
      end
      if (!seen) begin
         checkOutput("done_timeout", 32'd0, 32'd1);
      end
      exp_held_addr = new_hold;
      @(negedge clk);
      checkOutput("idle_busy", 32'(busy), 32'd0);
      checkOutput("done_pulse", 32'(done), 32'd0);
      checkOutput("fault_pulse", 32'(fault), 32'd0);
      checkOutput("xfer_count", xfer_count - base, flt ? 0 : n);
      checkOutput("idle_addr", mem_address, exp_held_addr);
      start = 1'b0;
   endtask

   // Directed scenarios, a random request stream, an aborted write and a final RAM sweep.
   initial begin
      logic [1:0]  rs;
      logic [31:0] ra;
      logic [31:0] w;
      logic [7:0]  rd;
      bit          seen_done;
      checks        = 0;
      failures      = 0;
      rst_n         = 1'b0;
      start         = 1'b0;
      rw            = 1'b0;
      size          = 2'd0;
      sign_ext      = 1'b0;
      addr          = 32'd0;
      wdata         = 32'd0;
      bd_active     = 1'b1;
      bd_en         = 1'b0;
      bd_rw         = 1'b0;
      bd_addr       = 8'd0;
      bd_data       = 8'd0;
      exp_rdata     = 32'd0;
      exp_held_addr = 32'd0;
      @(negedge clk);
      checkResetOutputs();

      for (int i = 0; i < 256; i++) begin
         ref_mem[i] = 8'($urandom);
      end
      ref_mem[8]  = 8'h12;
      ref_mem[9]  = 8'h34;
      ref_mem[10] = 8'h56;
      ref_mem[11] = 8'h78;
      ref_mem[3]  = 8'h80;
      for (int i = 0; i < 256; i++) begin
         backdoorWrite(8'(i), ref_mem[i]);
      end
      @(negedge clk);
      checkResetOutputs();

      rst_n = 1'b1;
      applyStimulus(1'b0, 2'd2, 1'b0, 32'd8, 32'd0);
      checkOutput("word_read_8", rdata, 32'h12345678);
      applyStimulus(1'b0, 2'd0, 1'b1, 32'd3, 32'd0);
      checkOutput("byte_read_sext", rdata, 32'hFFFFFF80);
      applyStimulus(1'b0, 2'd0, 1'b0, 32'd3, 32'd0);
      checkOutput("byte_read_zext", rdata, 32'h00000080);
      applyStimulus(1'b1, 2'd1, 1'b0, 32'd6, 32'h0000BEEF);
      applyStimulus(1'b0, 2'd1, 1'b0, 32'd6, 32'd0);
      checkOutput("half_readback", rdata, 32'h0000BEEF);
      applyStimulus(1'b0, 2'd2, 1'b0, 32'd5, 32'd0);
      checkOutput("misaligned_rdata", rdata, 32'h0000BEEF);
      applyStimulus(1'b0, 2'd1, 1'b0, 32'h101, 32'd0);
      checkOutput("range_rdata", rdata, 32'h0000BEEF);

      for (int r = 0; r < 80; r++) begin
         rs = 2'($urandom_range(0, 6) / 2);
         ra = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(256, 400)) : 32'($urandom_range(0, 255));
         if (rs == 2'd1 && $urandom_range(0, 3) != 0) ra[0] = 1'b0;
         if (rs == 2'd2 && $urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
         applyStimulus(1'($urandom), rs, 1'($urandom), ra, $urandom);
      end

      w        = $urandom;
      start    = 1'b1;
      rw       = 1'b1;
      size     = 2'd2;
      sign_ext = 1'b0;
      addr     = 32'h20;
      wdata    = w;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      checkOutput("abort_addr0", mem_address, 32'h20);
      @(negedge clk);
      checkOutput("abort_addr1", mem_address, 32'h21);
      ref_mem[8'h20] = w[31:24];
      rst_n = 1'b0;
      #1;
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_enable", 32'(mem_enable), 32'd0);
      exp_rdata     = 32'd0;
      exp_held_addr = 32'd0;
      checkResetOutputs();
      seen_done = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (done) seen_done = 1'b1;
      end
      checkOutput("abort_no_done", 32'(seen_done), 32'd0);
      for (int k = 0; k < 4; k++) begin
         backdoorRead(8'(32'h20 + k), rd);
         checkOutput("abort_ram", 32'(rd), 32'(ref_mem[8'(32'h20 + k)]));
      end

      for (int r = 0; r < 20; r++) begin
         rs = 2'($urandom_range(0, 2));
         ra = 32'($urandom_range(0, 255));
         if (rs == 2'd1) ra[0] = 1'b0;
         if (rs == 2'd2) ra[1:0] = 2'b00;
         applyStimulus(1'($urandom), rs, 1'($urandom), ra, $urandom);
      end

      @(negedge clk);
      for (int i = 0; i < 256; i++) begin
         backdoorRead(8'(i), rd);
         checkOutput("ram_final", 32'(rd), 32'(ref_mem[i]));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: RAM_DEPTH, 256, number of byte locations in the attached data RAM; the legal byte address range is 0..RAM_DEPTH-1.
REQ-002 Clk  in  1  single clock; all state changes on its rising edge.
REQ-003 Reset  in  1  asynchronous, active-low reset.
REQ-004 Start  in  1  request strobe from the pipeline; sampled only in IDLE.
REQ-005 RW  in  1  access type: 0 = read, 1 = write (same encoding as the RAM ReadWrite).
REQ-006 Size  in  2  access width: 00 = byte, 01 = halfword, 10 = word, 11 = reserved.
REQ-007 SignExt  in  1  read result for byte/halfword: 1 = sign-extend, 0 = zero-extend.
REQ-008 Addr  in  32  byte address of the first (most significant) byte of the access.
REQ-009 WData  in  32  store data, right-justified.
REQ-010 RData  out  32  load result; valid while Done=1.
REQ-011 Busy  out  1  high from the accept edge until Done has been issued.
REQ-012 Done  out  1  one-cycle completion pulse.
REQ-013 Fault  out  1  one-cycle pulse coincident with Done when the request is rejected.
REQ-014 MemEnable  out  1  RAM Enable, high for exactly one cycle per byte transfer.
REQ-015 MemReadWrite  out  1  RAM ReadWrite.
REQ-016 MemAddress  out  32  RAM Address.
REQ-017 MemDataOut  out  8  byte presented to the RAM DataIn; upper RAM DataIn bits are tied to 0.
REQ-018 MemDataIn  in  8  RAM DataOut[7:0], read combinationally in the same cycle MemEnable is high.

Function
REQ-019 FSM states SHALL be IDLE, ACCESS and FINISH, with transitions IDLE->ACCESS (legal Start), IDLE->FINISH (faulting Start), ACCESS->FINISH (last byte) and FINISH->IDLE.
REQ-020 In IDLE with Start=1, the block SHALL latch RW, Size, SignExt, Addr and WData at that edge; later input changes SHALL have no effect on the request.
REQ-021 While Busy=1, Start SHALL be ignored, with no queuing.
REQ-022 A request SHALL fault when any of the following holds: Size=11; Size=01 with Addr[0]=1; Size=10 with Addr[1:0]!=0; Addr>=RAM_DEPTH.
REQ-023 A faulting request SHALL produce no MemEnable pulse and SHALL spend one cycle in FINISH with Done=1, Fault=1 and RData unchanged.
REQ-024 A legal request SHALL spend N = 1, 2 or 4 ACCESS cycles (byte, halfword, word), with a 2-bit byte counter k running 0..N-1.
REQ-025 In ACCESS cycle k, the outputs SHALL be MemEnable=1, MemAddress=Addr+k and MemReadWrite=RW.
REQ-026 Byte order SHALL be big-endian: byte k carries data bits [8(N-k)-1 : 8(N-k-1)].
REQ-027 On a write, MemDataOut SHALL equal the byte-k slice of WData, and RData SHALL be left unchanged.
REQ-028 On a read, MemDataIn SHALL be captured into a shift register at the end of each ACCESS cycle.
REQ-029 In FINISH after a read, RData SHALL hold the assembled value, zero- or sign-extended per SignExt (word reads ignore SignExt).
REQ-030 Done SHALL be asserted exactly N+1 cycles after the accept edge for a legal request, and 1 cycle after it for a faulting request.
REQ-031 Start sampled high in FINISH SHALL be ignored; a new request is accepted only in IDLE, giving a back-to-back throughput of one request per N+2 cycles.
REQ-032 In IDLE and FINISH, the RAM-side outputs SHALL be MemEnable=0, MemReadWrite=0, MemAddress held and MemDataOut=0.

Reset
REQ-033 On Reset=0, the block SHALL immediately enter IDLE, independent of Clk.
REQ-034 On Reset=0, the outputs SHALL go to Busy=0, Done=0, Fault=0, MemEnable=0, MemReadWrite=0, MemAddress=0, MemDataOut=0 and RData=0.
REQ-035 A reset during ACCESS SHALL abort the request with no Done; bytes already written remain in the RAM.
REQ-036 The first Start SHALL be accepted on the first rising edge after Reset deasserts.

Structure
REQ-037 A shared package mem_pkg SHALL hold the Size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the FSM state encoding and RAM_DEPTH.
REQ-038 The block SHALL contain one sub-module, mem_extend (combinational), that takes the assembled bytes, Size and SignExt and produces the 32-bit RData value.
REQ-039 The bench SHALL instantiate data_ram256x8 as the responder.

Verification
REQ-040 Preload RAM[8..11] = 12,34,56,78; issue a word read at 8 -> four MemEnable pulses at addresses 8..11, Done at cycle 5, RData=0x12345678.
REQ-041 Issue a byte read at 3 with RAM[3]=0x80: with SignExt=1 -> RData=0xFFFFFF80; with SignExt=0 -> RData=0x00000080.
REQ-042 Issue a halfword write of 0xBEEF at 6 -> MemDataOut=0xBE at address 6, then 0xEF at address 7; Done after 3 cycles; readback gives 0x0000BEEF.
REQ-043 Issue a word read at 5, then a halfword read at 0x101 -> each gives Done=1 and Fault=1 one cycle after accept, with no MemEnable and RData unchanged.
REQ-044 Assert Reset during the 2nd byte of a word write at 0x20 -> Busy drops immediately, no Done; RAM[0x20] holds the new byte and RAM[0x21..0x23] keep their old values.
REQ-045 Toggle Start while Busy, including during the FINISH cycle -> no extra request is accepted and the transfer count is unchanged.
